apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
Shares one APB master port between NUM_REQ on-chip requesters. Each requester presents a single read or write command. The block grants requesters in round-robin order and sequences the APB IDLE/SETUP/ACCESS phases for the granted command. It returns a per-requester completion pulse with the read data and error status. It sits between local command sources and the APB fabric, and it is the only driver of psel/penable on that bus.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16; IDX_W = $clog2(NUM_REQ)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_i  in  NUM_REQ  per-requester request; held high until matching done_o bit seen
req_write_i  in  NUM_REQ  per-requester direction; 1 = write, 0 = read
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
gnt_o  out  NUM_REQ  one-hot; owner of the current transfer (SETUP and ACCESS)
done_o  out  NUM_REQ  one-hot completion pulse
rdata_o  out  DATA_W  read data; valid only while done_o != 0 and the transfer is a read
err_o  out  1  slave error; valid only while done_o != 0
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
pready_i  in  1  APB ready
prdata_i  in  DATA_W  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- Reset values: state IDLE, last-grant pointer = NUM_REQ-1, captured index/addr/write/wdata = 0. All outputs = 0.
- State machine:
  - IDLE -> SETUP when |req_i.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when pready_i; otherwise stay in ACCESS.
  - No direct ACCESS->SETUP transition. There is always at least one IDLE cycle between transfers.
- Arbitration, in IDLE only:
  - Winner = first i with req_i[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - On the IDLE->SETUP edge, capture the winner index, req_addr_i, req_write_i and req_wdata_i slices. Set last = winner.
  - Requests asserted during SETUP/ACCESS wait for the next IDLE.
  - After reset, requester 0 has highest priority.
- APB outputs are driven from captured registers only:
  - psel_o = SETUP|ACCESS; penable_o = ACCESS.
  - paddr_o and pwrite_o = captured values in SETUP/ACCESS; 0 in IDLE.
  - pwdata_o = captured wdata when the captured write = 1; otherwise 0.
  - All are stable from SETUP through the last ACCESS cycle, even if req_i or the input buses change.
- gnt_o[idx] = 1 during SETUP/ACCESS, else 0.
- Completion is combinational in the ACCESS cycle with pready_i = 1:
  - done_o[idx] = 1.
  - rdata_o = prdata_i when the transfer is a read, else 0.
  - err_o = pslverr_i.
  - done_o, rdata_o and err_o are 0 at all other times.
- Requester contract: deassert req_i[i] (or present a new command) in the cycle after done_o[i].
  - A requester that keeps req_i high is re-arbitrated as a new request in the following IDLE cycle.
  - This gives the minimum 3-cycle per-transfer cadence: SETUP, ACCESS, IDLE.
- Timing: req_i rises in cycle N, bus idle -> SETUP in N+1, ACCESS in N+2, earliest done_o in N+2. Each low pready_i cycle adds one cycle.
- If req_i[idx] drops mid-transfer, the transfer still completes and done_o still pulses.
- Reset asserted mid-transfer: psel_o, penable_o and gnt_o drop asynchronously. No done_o is produced. The pointer returns to NUM_REQ-1.

Test Plan:
- Single read: req_i=0001, addr0=0xDEAD_CAFE, pready_i tied 1, prdata_i=0x1234_5678 -> psel in cycle 1, penable in cycle 2, done_o=0001 and rdata_o=0x1234_5678 in cycle 2, err_o=0, back in IDLE in cycle 3.
- Write with wait states: requester 2 writes 0xA5A5_0001 to 0x10; pready_i low for 3 ACCESS cycles -> paddr_o, pwdata_o and pwrite_o held stable, penable_o high for 4 cycles, done_o=0100 only in the 4th.
- Round robin: req_i=1111 held, each requester dropping its req after its own done -> grant order 0,1,2,3. Then re-raise 0 and 3 together after last=3 -> 0 wins.
- Fairness under contention: requesters 1 and 2 each re-raise req immediately after their done -> grants strictly alternate 1,2,1,2 over 8 transfers; no requester is granted twice in a row while the other is waiting.
- Slave error: read from requester 3 with pslverr_i=1 on the ready cycle -> done_o=1000, err_o=1. In the next transfer, with pslverr_i=0, err_o=0.
- Reset in ACCESS: assert reset while pready_i=0 -> psel_o, penable_o and gnt_o = 0 immediately, no done_o. After release with req_i=0110 -> requester 1 granted first.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters.
// Sequences IDLE/SETUP/ACCESS for the granted command and pulses done_o on completion.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic                      pready_i,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pslverr_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    int                cand;
    logic              bus_active;
    logic [NUM_REQ-1:0] owner_onehot;

    // Search starts just after the last winner so every waiting requester is reached
    // within NUM_REQ grants.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!win_found && req_i[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_SETUP;
                    last_d  = win_idx;
                    idx_d   = win_idx;
                    addr_d  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                    write_d = req_write_i[win_idx];
                    wdata_d = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // Bus-side outputs come only from captured registers so they stay stable
    // while requesters change their command inputs mid-transfer.
    assign bus_active   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign owner_onehot = NUM_REQ'(1) << idx_q;

    assign psel_o    = bus_active;
    assign penable_o = (state_q == ST_ACCESS);
    assign paddr_o   = bus_active ? addr_q : '0;
    assign pwrite_o  = bus_active ? write_q : 1'b0;
    assign pwdata_o  = write_q ? wdata_q : '0;
    assign gnt_o     = bus_active ? owner_onehot : '0;

    always_comb begin
        done_o  = '0;
        rdata_o = '0;
        err_o   = 1'b0;
        if (state_q == ST_ACCESS && pready_i) begin
            done_o  = owner_onehot;
            rdata_o = write_q ? '0 : prdata_i;
            err_o   = pslverr_i;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter: one task per scenario,
// inputs driven 1 ns after the rising edge, outputs checked 2 ns after it.
module tb_apb_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        req_write_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      err_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [ADDR_W-1:0]         paddr_o;
    logic                      pwrite_o;
    logic [DATA_W-1:0]         pwdata_o;
    logic                      pready_i;
    logic [DATA_W-1:0]         prdata_i;
    logic                      pslverr_i;

    int n_checks = 0;
    int n_fail   = 0;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .paddr_o     (paddr_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .pslverr_i   (pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset       = 1'b1;
        req_i       = '0;
        req_write_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        pready_i    = 1'b1;
        prdata_i    = '0;
        pslverr_i   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Advances until a done pulse is visible; reports which requester finished.
    task automatic wait_done(output int idx, output bit timed_out);
        idx       = -1;
        timed_out = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            #1;
            if (done_o != '0) begin
                timed_out = 1'b0;
                for (int i = 0; i < NUM_REQ; i++)
                    if (done_o[i]) idx = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_checks++;
        if ({psel_o, penable_o, pwrite_o, err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000", {psel_o, penable_o, pwrite_o, err_o});
        end
        n_checks++;
        if ({gnt_o, done_o} !== 8'h00 || paddr_o !== '0 || pwdata_o !== '0 || rdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: gnt=%b done=%b paddr=%h pwdata=%h rdata=%h required all 0",
                     gnt_o, done_o, paddr_o, pwdata_o, rdata_o);
        end
    endtask

    task automatic test_single_read;
        do_reset();
        req_addr_i[0 +: ADDR_W] = 32'hDEAD_CAFE;
        prdata_i = 32'h1234_5678;
        req_i    = 4'b0001;
        #1;
        n_checks++;
        if (psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_cycle0_psel: got %b required 0", psel_o);
        end
        tick(); #1;
        n_checks++;
        if ({psel_o, penable_o} !== 2'b10 || gnt_o !== 4'b0001 || paddr_o !== 32'hDEAD_CAFE
            || pwrite_o !== 1'b0 || done_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL rd_setup: psel/pen=%b gnt=%b paddr=%h pwrite=%b done=%b required 10 0001 deadcafe 0 0000",
                     {psel_o, penable_o}, gnt_o, paddr_o, pwrite_o, done_o);
        end
        tick(); #1;
        n_checks++;
        if ({psel_o, penable_o} !== 2'b11 || done_o !== 4'b0001 || rdata_o !== 32'h1234_5678
            || err_o !== 1'b0 || pwdata_o !== '0) begin
            n_fail++;
            $display("FAIL rd_access: psel/pen=%b done=%b rdata=%h err=%b pwdata=%h required 11 0001 12345678 0 0",
                     {psel_o, penable_o}, done_o, rdata_o, err_o, pwdata_o);
        end
        tick();
        req_i = '0;
        #1;
        n_checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || done_o !== '0 || gnt_o !== '0 || paddr_o !== '0) begin
            n_fail++;
            $display("FAIL rd_idle: psel=%b pen=%b done=%b gnt=%b paddr=%h required all 0",
                     psel_o, penable_o, done_o, gnt_o, paddr_o);
        end
    endtask

    task automatic test_write_wait;
        do_reset();
        req_write_i[2]                   = 1'b1;
        req_addr_i[2*ADDR_W +: ADDR_W]   = 32'h0000_0010;
        req_wdata_i[2*DATA_W +: DATA_W]  = 32'hA5A5_0001;
        pready_i = 1'b0;
        req_i    = 4'b0100;
        tick(); #1;
        n_checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b0 || gnt_o !== 4'b0100 || paddr_o !== 32'h10
            || pwrite_o !== 1'b1 || pwdata_o !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL wr_setup: psel=%b pen=%b gnt=%b paddr=%h pwrite=%b pwdata=%h required 1 0 0100 10 1 a5a50001",
                     psel_o, penable_o, gnt_o, paddr_o, pwrite_o, pwdata_o);
        end
        // Scramble the requester's command; the bus must keep the captured copy.
        req_addr_i[2*ADDR_W +: ADDR_W]  = 32'hFFFF_FFFF;
        req_wdata_i[2*DATA_W +: DATA_W] = 32'h0;
        req_write_i[2]                  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 4) pready_i = 1'b1;
            #1;
            n_checks++;
            if (penable_o !== 1'b1 || paddr_o !== 32'h10 || pwdata_o !== 32'hA5A5_0001 || pwrite_o !== 1'b1
                || done_o !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("FAIL wr_access_%0d: pen=%b paddr=%h pwdata=%h pwrite=%b done=%b", c,
                         penable_o, paddr_o, pwdata_o, pwrite_o, done_o);
            end
        end
        tick();
        req_i = '0;
        #1;
        n_checks++;
        if (psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle_psel: got %b required 0", psel_o);
        end
    endtask

    task automatic test_round_robin;
        int  idx;
        bit  to;
        do_reset();
        req_i = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_done(idx, to);
            n_checks++;
            if (to || idx != k) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got %0d (timeout %0d) required %0d", k, idx, to, k);
            end
            tick();
            req_i[k] = 1'b0;
        end
        req_i = 4'b1001;
        wait_done(idx, to);
        n_checks++;
        if (to || idx != 0) begin
            n_fail++;
            $display("FAIL rr_wrap: got %0d (timeout %0d) required 0", idx, to);
        end
        tick();
        req_i = '0;
    endtask

    task automatic test_fairness;
        int idx;
        bit to;
        do_reset();
        req_i = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            wait_done(idx, to);
            n_checks++;
            if (to || idx != ((k % 2 == 0) ? 1 : 2)) begin
                n_fail++;
                $display("FAIL fair_%0d: got %0d (timeout %0d) required %0d", k, idx, to, (k % 2 == 0) ? 1 : 2);
            end
            tick();
        end
        req_i = '0;
    endtask

    task automatic test_slave_error;
        int idx;
        bit to;
        do_reset();
        req_addr_i[3*ADDR_W +: ADDR_W] = 32'h0000_0300;
        prdata_i  = 32'hCAFE_0003;
        pslverr_i = 1'b1;
        req_i     = 4'b1000;
        wait_done(idx, to);
        n_checks++;
        if (to || done_o !== 4'b1000 || err_o !== 1'b1 || rdata_o !== 32'hCAFE_0003) begin
            n_fail++;
            $display("FAIL err_set: done=%b err=%b rdata=%h timeout=%0d required 1000 1 cafe0003 0",
                     done_o, err_o, rdata_o, to);
        end
        tick();
        pslverr_i = 1'b0;
        wait_done(idx, to);
        n_checks++;
        if (to || done_o !== 4'b1000 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: done=%b err=%b timeout=%0d required 1000 0 0", done_o, err_o, to);
        end
        tick();
        req_i = '0;
    endtask

    task automatic test_reset_in_access;
        int idx;
        bit to;
        do_reset();
        pready_i = 1'b0;
        req_i    = 4'b0010;
        tick(); tick(); #1;
        n_checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b1 || gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_pre_access: psel=%b pen=%b gnt=%b required 1 1 0010", psel_o, penable_o, gnt_o);
        end
        // Reset lands mid-cycle, well away from any clock edge.
        reset = 1'b1;
        #1;
        n_checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || gnt_o !== '0 || done_o !== '0) begin
            n_fail++;
            $display("FAIL rst_async: psel=%b pen=%b gnt=%b done=%b required all 0", psel_o, penable_o, gnt_o, done_o);
        end
        tick();
        reset    = 1'b0;
        pready_i = 1'b1;
        req_i    = 4'b0110;
        wait_done(idx, to);
        n_checks++;
        if (to || idx != 1) begin
            n_fail++;
            $display("FAIL rst_pointer: got %0d (timeout %0d) required 1", idx, to);
        end
        tick();
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_fairness();
        test_slave_error();
        test_reset_in_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
